io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the core's single 8-bit-address I/O bus between two masters: the CPU/MMU I/O port and a secondary debug/DMA master (e.g. a UART debug bridge).
- The CPU cannot stall, so it has absolute priority and passes straight through to the bus with no added latency.
- The debug master's transaction is latched and issued on the first cycle in which the CPU is not using the bus. It completes with a one-cycle acknowledge.
- Sits between the MMU I/O port and the peripheral I/O bus inside the core top level.

Parameters:
- ADDR_W, 8, I/O address width.
- DATA_W, 32, I/O data width.
- STARVE_LIMIT, 255, count of consecutive CPU-blocked pending cycles at which dbg_starved asserts. Range 1..65535; the counter is 16 bits.

Ports:
- clk  in  1  system clock, rising edge.
- resetb  in  1  synchronous reset, active low.
- cpu_io_addr  in  ADDR_W  CPU I/O address.
- cpu_io_en  in  1  CPU I/O access this cycle.
- cpu_io_we  in  1  CPU write strobe (valid with cpu_io_en).
- cpu_io_data_write  in  DATA_W  CPU write data.
- cpu_io_data_read  out  DATA_W  read data returned to CPU.
- dbg_req  in  1  debug request pulse/level, sampled only in IDLE.
- dbg_we  in  1  debug write (1) / read (0).
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_busy  out  1  debug request accepted and not yet acknowledged.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  captured read data, valid with dbg_ack and held until the next ack.
- dbg_starved  out  1  pending request blocked for at least STARVE_LIMIT cycles.
- io_addr  out  ADDR_W  peripheral bus address.
- io_en  out  1  peripheral bus enable.
- io_we  out  1  peripheral bus write.
- io_data_write  out  DATA_W  peripheral bus write data.
- io_data_read  in  DATA_W  peripheral read data, valid in the same cycle as io_en.

Behaviour:
- Reset is synchronous: at a clk edge with resetb=0 the FSM goes to IDLE and the following registers clear: dbg_busy=0, dbg_ack=0, dbg_rdata=0, dbg_starved=0, starvation counter=0, latched request fields=0.
- Reset mid-operation silently drops any pending debug request; no ack is produced.
- Bus mux (combinational):
  - cpu_io_en=1: io_* = cpu_io_*.
  - Else, in state PEND: io_en=1, io_we=lat_we, io_addr=lat_addr, io_data_write=lat_wdata.
  - Else: io_en=0, io_we=0, io_addr=0, io_data_write=0.
  - cpu_io_data_read = io_data_read at all times (combinational pass-through, zero added latency).
- FSM states: IDLE, PEND, ACK.
  - IDLE: if dbg_req=1, latch dbg_we/dbg_addr/dbg_wdata, go to PEND, dbg_busy=1 next cycle.
  - PEND, cpu_io_en=1: stay in PEND; increment the counter, saturating at STARVE_LIMIT; dbg_starved=1 once counter==STARVE_LIMIT.
  - PEND, cpu_io_en=0: the debug access is driven on the bus this cycle. At the edge: capture io_data_read into dbg_rdata if lat_we=0 (dbg_rdata is unchanged on writes), clear counter and dbg_starved, go to ACK.
  - ACK: dbg_ack=1 for exactly this cycle, dbg_busy=0, go to IDLE. A dbg_req in the ACK cycle is ignored.
- Latency: request at edge N gives PEND from N+1. With an idle CPU, the bus access is in cycle N+1 and dbg_ack is high in cycle N+2. Minimum spacing between accepted requests is 3 cycles.
- dbg_req while busy or in ACK is ignored; no queueing. The requester must wait for dbg_ack before issuing again.
- The CPU is never delayed. A CPU access in the same cycle as a debug issue opportunity always wins, and the debug access slips.
- Debug write data/address are taken only from the latch. Input changes after acceptance have no effect.
- With STARVE_LIMIT=1, dbg_starved asserts after the first blocked cycle. The counter never wraps.

Test Plan:
- CPU pass-through: cpu_io_en=1, we=1, addr=0x10, wdata=0xDEADBEEF, no debug activity -> io_en=1, io_addr=0x10, io_data_write=0xDEADBEEF in the same cycle. CPU read with io_data_read=0x12345678 -> cpu_io_data_read=0x12345678 combinationally.
- Debug read, idle CPU: dbg_req pulse with addr=0x20, we=0; io_data_read=0xCAFEF00D -> io_en=1/io_addr=0x20/io_we=0 exactly one cycle later; dbg_ack one cycle after that with dbg_rdata=0xCAFEF00D; dbg_busy high for exactly the PEND cycle.
- Contention: debug write addr=0x04, data=0x5A accepted while cpu_io_en is held high for 5 cycles -> no debug bus cycle during those 5 cycles and CPU values seen on the bus. Debug write then appears in the first cycle with cpu_io_en=0; ack follows the next cycle.
- Starvation: STARVE_LIMIT=4, CPU busy for 10 cycles with a pending request -> dbg_starved rises on the 4th blocked cycle edge, stays high, and clears at the issue edge.
- Ignored request: assert dbg_req again while busy and in ACK -> exactly one bus transaction and one ack.
- Reset mid-PEND: resetb=0 for one cycle while pending -> IDLE, no debug bus access, no dbg_ack, all outputs at reset values.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the core's I/O bus: the CPU passes straight through with absolute
// priority, and a single latched debug/DMA access is issued in the first cycle the CPU leaves free.
module io_bus_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 255
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [ADDR_W-1:0] cpu_io_addr,
    input  logic              cpu_io_en,
    input  logic              cpu_io_we,
    input  logic [DATA_W-1:0] cpu_io_data_write,
    output logic [DATA_W-1:0] cpu_io_data_read,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_busy,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_starved,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_en,
    output logic              io_we,
    output logic [DATA_W-1:0] io_data_write,
    input  logic [DATA_W-1:0] io_data_read
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

    state_t              state;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [15:0]         starve_cnt;
    logic [15:0]         cnt_next;

    // Saturating increment: the counter parks at the limit and never wraps.
    assign cnt_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 16'd1;

    assign cpu_io_data_read = io_data_read;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        io_en         = 1'b0;
        io_we         = 1'b0;
        io_addr       = '0;
        io_data_write = '0;
        if (cpu_io_en) begin
            io_en         = 1'b1;
            io_we         = cpu_io_we;
            io_addr       = cpu_io_addr;
            io_data_write = cpu_io_data_write;
        end else if (state == PEND) begin
            io_en         = 1'b1;
            io_we         = lat_we;
            io_addr       = lat_addr;
            io_data_write = lat_wdata;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            starve_cnt  <= '0;
            dbg_busy    <= 1'b0;
            dbg_ack     <= 1'b0;
            dbg_rdata   <= '0;
            dbg_starved <= 1'b0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg_req) begin
                        lat_we    <= dbg_we;
                        lat_addr  <= dbg_addr;
                        lat_wdata <= dbg_wdata;
                        dbg_busy  <= 1'b1;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (cpu_io_en) begin
                        starve_cnt  <= cnt_next;
                        dbg_starved <= (cnt_next == LIMIT);
                    end else begin
                        // The debug access owns the bus this cycle; read data is valid now.
                        if (!lat_we) begin
                            dbg_rdata <= io_data_read;
                        end
                        starve_cnt  <= '0;
                        dbg_starved <= 1'b0;
                        dbg_busy    <= 1'b0;
                        dbg_ack     <= 1'b1;
                        state       <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: inputs change and outputs are checked at the falling edge,
// so registered outputs reflect the previous rising edge and the combinational mux its inputs.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetb;
    logic [7:0]  cpu_io_addr;
    logic        cpu_io_en;
    logic        cpu_io_we;
    logic [31:0] cpu_io_data_write;
    logic [31:0] cpu_io_data_read;
    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_busy;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_starved;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;

    int n_checks = 0;
    int n_errors = 0;
    int bus_cnt;
    int ack_cnt;

    always #5 clk = ~clk;

    io_bus_arbiter #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk              (clk),
        .resetb           (resetb),
        .cpu_io_addr      (cpu_io_addr),
        .cpu_io_en        (cpu_io_en),
        .cpu_io_we        (cpu_io_we),
        .cpu_io_data_write(cpu_io_data_write),
        .cpu_io_data_read (cpu_io_data_read),
        .dbg_req          (dbg_req),
        .dbg_we           (dbg_we),
        .dbg_addr         (dbg_addr),
        .dbg_wdata        (dbg_wdata),
        .dbg_busy         (dbg_busy),
        .dbg_ack          (dbg_ack),
        .dbg_rdata        (dbg_rdata),
        .dbg_starved      (dbg_starved),
        .io_addr          (io_addr),
        .io_en            (io_en),
        .io_we            (io_we),
        .io_data_write    (io_data_write),
        .io_data_read     (io_data_read)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Move to the middle of the next cycle and let combinational outputs settle after input changes.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetb            = 1'b0;
        cpu_io_addr       = '0;
        cpu_io_en         = 1'b0;
        cpu_io_we         = 1'b0;
        cpu_io_data_write = '0;
        dbg_req           = 1'b0;
        dbg_we            = 1'b0;
        dbg_addr          = '0;
        dbg_wdata         = '0;
        io_data_read      = '0;

        // Reset state
        next_cycle(); next_cycle();
        resetb = 1'b1;
        settle();
        check("rst_busy", 32'(dbg_busy), 32'd0);
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_rdata", dbg_rdata, 32'h0);
        check("rst_starved", 32'(dbg_starved), 32'd0);
        check("rst_io_en", 32'(io_en), 32'd0);
        check("rst_io_addr", 32'(io_addr), 32'd0);

        // CPU pass-through write, then read
        next_cycle();
        cpu_io_en = 1'b1; cpu_io_we = 1'b1; cpu_io_addr = 8'h10; cpu_io_data_write = 32'hDEADBEEF;
        settle();
        check("cpu_wr_en", 32'(io_en), 32'd1);
        check("cpu_wr_we", 32'(io_we), 32'd1);
        check("cpu_wr_addr", 32'(io_addr), 32'h10);
        check("cpu_wr_data", io_data_write, 32'hDEADBEEF);
        next_cycle();
        cpu_io_we = 1'b0; cpu_io_addr = 8'h14; io_data_read = 32'h12345678;
        settle();
        check("cpu_rd_we", 32'(io_we), 32'd0);
        check("cpu_rd_addr", 32'(io_addr), 32'h14);
        check("cpu_rd_data", cpu_io_data_read, 32'h12345678);
        check("cpu_rd_no_busy", 32'(dbg_busy), 32'd0);

        // Debug read with idle CPU; inputs change after acceptance to prove the latch is used
        next_cycle();
        cpu_io_en = 1'b0; cpu_io_data_write = '0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20; dbg_wdata = 32'h0;
        settle();
        check("dr_req_io_en", 32'(io_en), 32'd0);
        next_cycle();
        dbg_req = 1'b0; dbg_addr = 8'h99; dbg_we = 1'b1; io_data_read = 32'hCAFEF00D;
        settle();
        check("dr_io_en", 32'(io_en), 32'd1);
        check("dr_io_addr", 32'(io_addr), 32'h20);
        check("dr_io_we", 32'(io_we), 32'd0);
        check("dr_busy", 32'(dbg_busy), 32'd1);
        check("dr_ack_early", 32'(dbg_ack), 32'd0);
        next_cycle();
        io_data_read = 32'h0BAD0BAD;
        settle();
        check("dr_ack", 32'(dbg_ack), 32'd1);
        check("dr_rdata", dbg_rdata, 32'hCAFEF00D);
        check("dr_busy_ack", 32'(dbg_busy), 32'd0);
        check("dr_io_en_ack", 32'(io_en), 32'd0);
        next_cycle();
        settle();
        check("dr_ack_pulse", 32'(dbg_ack), 32'd0);
        check("dr_rdata_hold", dbg_rdata, 32'hCAFEF00D);

        // Contention: debug write accepted while CPU holds the bus for 5 cycles
        next_cycle();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h04; dbg_wdata = 32'h5A;
        cpu_io_en = 1'b1; cpu_io_we = 1'b1; cpu_io_addr = 8'h30; cpu_io_data_write = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("ct_cpu_addr%0d", i), 32'(io_addr), 32'h30);
            check($sformatf("ct_cpu_data%0d", i), io_data_write, 32'h11111111);
            check($sformatf("ct_ack%0d", i), 32'(dbg_ack), 32'd0);
            next_cycle();
            dbg_req = 1'b0; dbg_wdata = 32'hFFFFFFFF; dbg_addr = 8'hEE;
        end
        // Four blocked PEND cycles reach the limit of 4
        cpu_io_en = 1'b0; io_data_read = 32'h77777777;
        settle();
        check("ct_io_en", 32'(io_en), 32'd1);
        check("ct_io_addr", 32'(io_addr), 32'h04);
        check("ct_io_we", 32'(io_we), 32'd1);
        check("ct_io_data", io_data_write, 32'h5A);
        check("ct_busy", 32'(dbg_busy), 32'd1);
        check("ct_starved", 32'(dbg_starved), 32'd1);
        next_cycle();
        settle();
        check("ct_ack", 32'(dbg_ack), 32'd1);
        check("ct_rdata_kept", dbg_rdata, 32'hCAFEF00D);
        check("ct_starved_clr", 32'(dbg_starved), 32'd0);

        // Starvation: 10 blocked cycles with limit 4
        next_cycle();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h40;
        cpu_io_en = 1'b0;
        next_cycle();
        dbg_req = 1'b0; cpu_io_en = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            settle();
            check($sformatf("sv_starved%0d", j), 32'(dbg_starved), (j >= 5) ? 32'd1 : 32'd0);
            next_cycle();
        end
        cpu_io_en = 1'b0; io_data_read = 32'hA5A5A5A5;
        settle();
        check("sv_issue_addr", 32'(io_addr), 32'h40);
        check("sv_issue_starved", 32'(dbg_starved), 32'd1);
        next_cycle();
        settle();
        check("sv_ack", 32'(dbg_ack), 32'd1);
        check("sv_rdata", dbg_rdata, 32'hA5A5A5A5);
        check("sv_starved_clr", 32'(dbg_starved), 32'd0);

        // Ignored requests while busy and in ACK
        next_cycle();
        bus_cnt = 0; ack_cnt = 0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 32'h1;
        for (int k = 0; k < 6; k++) begin
            settle();
            if (io_en) bus_cnt++;
            if (dbg_ack) ack_cnt++;
            next_cycle();
            dbg_addr = 8'h77;
            if (k == 2) dbg_req = 1'b0;
        end
        check("ig_bus_count", 32'(bus_cnt), 32'd1);
        check("ig_ack_count", 32'(ack_cnt), 32'd1);

        // Reset while pending: request dropped, no access, no ack
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h60; dbg_wdata = 32'h2;
        cpu_io_en = 1'b1; cpu_io_addr = 8'h31;
        next_cycle();
        dbg_req = 1'b0;
        settle();
        check("rp_busy", 32'(dbg_busy), 32'd1);
        next_cycle();
        resetb = 1'b0;
        next_cycle();
        resetb = 1'b1; cpu_io_en = 1'b0;
        settle();
        check("rp_io_en", 32'(io_en), 32'd0);
        check("rp_busy_clr", 32'(dbg_busy), 32'd0);
        check("rp_rdata_clr", dbg_rdata, 32'h0);
        check("rp_starved", 32'(dbg_starved), 32'd0);
        bus_cnt = 0; ack_cnt = 0;
        for (int m = 0; m < 4; m++) begin
            settle();
            if (io_en) bus_cnt++;
            if (dbg_ack) ack_cnt++;
            next_cycle();
        end
        check("rp_no_bus", 32'(bus_cnt), 32'd0);
        check("rp_no_ack", 32'(ack_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
